// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate-format encodings for the decode/extend path
//
// Purpose: single source of truth for the immediate-format select encoding,
// shared by the control decoder and the immediate generator.
// Ports: none (package).
package imm_pkg;

  localparam int IMM_SRC_W = 3;

  // 3'b110 and 3'b111 are deliberately left unnamed: they mark an illegal format.
  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

endpackage

// File: rtl/imm_extend_decode.sv
// rtl/imm_extend_decode.sv - combinational immediate format decode and extension
//
// Purpose: turns a raw RV32 instruction word plus a format select into an
// XLEN-wide immediate and an illegal-format flag. No state.
// Parameters: XLEN (32 or 64) - width of the produced immediate.
// Ports:
//   instr    in  32         raw instruction word
//   imm_src  in  IMM_SRC_W  format select (imm_src_e, 110/111 illegal)
//   imm      out XLEN       extended immediate (0 for illegal formats)
//   illegal  out 1          format select was 110 or 111
module imm_extend_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  // Signed size casts do the sign extension, which keeps one expression
  // valid for both XLEN=32 and XLEN=64 (no zero-width replications).
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: imm = XLEN'($signed(instr[31:20]));
      IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_Z: imm = XLEN'(instr[19:15]);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate generator with valid/ready handshake
//
// Purpose: decode-to-execute immediate stage. Accepts an instruction and
// format select, presents the extended immediate one cycle later from
// registers only. Order preserved, nothing dropped or duplicated.
// Configuration macro: IMM_EXTEND_PIPE_SKID_EN - adds a skid register so that
// in_ready is a pure register output (no combinational path from out_ready).
// Parameters: XLEN (32 or 64).
// Ports:
//   clk          in  1          clock, rising edge
//   reset        in  1          synchronous active-high reset
//   in_valid     in  1          upstream offers an instruction
//   in_ready     out 1          instruction accepted this cycle if in_valid
//   in_instr     in  32         raw instruction word
//   in_imm_src   in  IMM_SRC_W  format select
//   out_valid    out 1          out_imm/out_illegal valid
//   out_ready    in  1          downstream consumes output this cycle
//   out_imm      out XLEN       extended immediate
//   out_illegal  out 1          format select was illegal
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMM_SRC_W-1:0] in_imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic                 out_illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            accept;

  imm_extend_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign accept = in_valid && in_ready;

`ifdef IMM_EXTEND_PIPE_SKID_EN
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic            skid_illegal;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up: the older skid entry has priority. An accept
      // cannot coincide with a full skid because in_ready is low then.
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          out_imm     <= dec_imm;
          out_illegal <= dec_illegal;
        end
      end
    end else if (accept) begin
      // Output stalled: park the one in-flight entry upstream could not see
      // the stall for in time.
      skid_valid   <= 1'b1;
      skid_imm     <= dec_imm;
      skid_illegal <= dec_illegal;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_imm     <= dec_imm;
        out_illegal <= dec_illegal;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe (XLEN 32 and 64)
module tb_imm_extend_pipe;

`ifdef IMM_EXTEND_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_imm_src = '0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;

  int checks = 0;
  int failures = 0;
  int dut_emits = 0;
  bit armed = 1'b0;

  typedef struct {
    logic [63:0] imm;
    logic        ill;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_illegal(out_illegal32)
  );

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_illegal(out_illegal64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference immediate as a signed integer, 64 bits wide; XLEN=32 uses the low half.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
    logic signed [63:0] r;
    case (s)
      3'd0: r = 64'($signed(i[31:20]));
      3'd1: r = 64'($signed({i[31:25], i[11:7]}));
      3'd2: r = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd3: r = 64'($signed(i[31:12])) * 64'sd4096;
      3'd4: r = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd5: r = 64'(i[19:15]);
      default: r = 64'sd0;
    endcase
    return r;
  endfunction

  // Model: a FIFO of capacity CAP; without the skid buffer a full slot may
  // still accept when it is being drained in the same cycle.
  function automatic bit model_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(negedge clk) begin : compare
    bit   rdy;
    bit   has;
    ent_t e;
    if (reset) begin
      q.delete();
    end else if (armed) begin
      rdy = model_ready();
      has = (q.size() != 0);
      chk("in_ready32", 64'(in_ready32), 64'(rdy));
      chk("in_ready64", 64'(in_ready64), 64'(rdy));
      chk("out_valid32", 64'(out_valid32), 64'(has));
      chk("out_valid64", 64'(out_valid64), 64'(has));
      if (has) begin
        chk("out_imm32", 64'(out_imm32), {32'd0, q[0].imm[31:0]});
        chk("out_imm64", out_imm64, q[0].imm);
        chk("out_illegal32", 64'(out_illegal32), 64'(q[0].ill));
        chk("out_illegal64", 64'(out_illegal64), 64'(q[0].ill));
      end
      if (out_valid64 && out_ready) dut_emits++;
      if (has && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        e.imm = ref_imm(in_instr, in_imm_src);
        e.ill = (in_imm_src >= 3'd6);
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] i, input logic [2:0] s);
    in_instr   = i;
    in_imm_src = s;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] bp_vec [4];
  logic [31:0] mix_vec[8];
  bit          mix_rdy[12];

  initial begin
    int idx;
    int e0;
    bit took;

    bp_vec  = '{32'h00100093, 32'hFFF00093, 32'h7FF00093, 32'h80000093};
    mix_vec = '{32'h00500113, 32'h00A12423, 32'h00208463, 32'h12345037,
                32'hFF5FF0EF, 32'h3402A073, 32'hDEADBEEF, 32'h80000000};
    mix_rdy = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_out_valid32", 64'(out_valid32), 64'd0);
    chk("rst_out_valid64", 64'(out_valid64), 64'd0);
    chk("rst_out_imm32", 64'(out_imm32), 64'd0);
    chk("rst_out_imm64", out_imm64, 64'd0);
    chk("rst_out_illegal64", 64'(out_illegal64), 64'd0);
    chk("rst_in_ready64", 64'(in_ready64), 64'd1);

    send(32'hFFF00093, 3'd0);
    chk("i_valid", 64'(out_valid32), 64'd1);
    chk("i_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
    chk("i_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("i_illegal", 64'(out_illegal32), 64'd0);
    send(32'hFE000EE3, 3'd2);
    chk("b_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
    chk("b_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'hFE112E23, 3'd1);
    chk("s_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
    send(32'h800000B7, 3'd3);
    chk("u_imm32", 64'(out_imm32), 64'h8000_0000);
    chk("u_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    send(32'h0080006F, 3'd4);
    chk("j_imm64", out_imm64, 64'd8);
    send(32'h000F8073, 3'd5);
    chk("z_imm64", out_imm64, 64'h1F);
    chk("z_illegal", 64'(out_illegal64), 64'd0);
    send(32'h000F8073, 3'd6);
    chk("ill6_imm64", out_imm64, 64'd0);
    chk("ill6_flag64", 64'(out_illegal64), 64'd1);
    chk("ill6_flag32", 64'(out_illegal32), 64'd1);
    send(32'h000F8073, 3'd7);
    chk("ill7_flag64", 64'(out_illegal64), 64'd1);
    @(posedge clk);
    #1;

    // Backpressure: three stalled cycles, then release.
    e0 = dut_emits;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid   = 1'b1;
      in_instr   = bp_vec[idx];
      in_imm_src = 3'd0;
      @(negedge clk);
      took = in_ready64;
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'(CAP));
    chk("bp_in_ready_low", 64'(in_ready64), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_valid = 1'b1;
      in_instr = bp_vec[idx];
      @(negedge clk);
      took = in_ready64;
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(idx), 64'd4);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_emitted", 64'(dut_emits - e0), 64'd4);

    // Mixed formats with irregular backpressure.
    idx = 0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      out_ready  = mix_rdy[c % 12];
      in_valid   = 1'b1;
      in_instr   = mix_vec[idx];
      in_imm_src = 3'(idx);
      @(negedge clk);
      took = in_ready64;
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mix_all_sent", 64'(idx), 64'd8);
    repeat (4) @(posedge clk);
    #1;

    // Reset with buffers full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_imm_src = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(out_valid64), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rst2_out_valid32", 64'(out_valid32), 64'd0);
    chk("rst2_out_valid64", 64'(out_valid64), 64'd0);
    chk("rst2_out_imm64", out_imm64, 64'd0);
    chk("rst2_in_ready32", 64'(in_ready32), 64'd1);
    chk("rst2_in_ready64", 64'(in_ready64), 64'd1);
    e0 = dut_emits;
    repeat (5) @(posedge clk);
    #1;
    chk("rst2_no_stale", 64'(dut_emits - e0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate generator for the RV32I datapath. It is the next generation of the combinational sign-extender. It takes a full instruction word plus an immediate-format select and returns an XLEN-wide immediate one cycle later, behind a valid/ready handshake. It adds XLEN=64 support, a CSR zero-extended immediate format and an illegal-format flag. It sits between the decode stage and the execute stage of the pipelined core.

## Interface
Parameters:
- XLEN, default 32: immediate output width; legal values are 32 and 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  block accepts the offered instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110/111 illegal.
- out_valid  out  1  out_imm and out_illegal are valid.
- out_ready  in  1  downstream consumes the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_illegal  out  1  in_imm_src was 110 or 111.

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Formats (sext = sign-extend to XLEN, zext = zero-extend to XLEN):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}). Upper bits replicate instr[31] when XLEN=64.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z: zext(instr[19:15]).
  - 110/111: imm = 0, out_illegal = 1. The entry still flows through the handshake.
- Output order equals acceptance order. No entry is dropped or duplicated.
- While out_valid && !out_ready, out_imm and out_illegal hold stable.
- Reset values: out_valid=0, out_imm=0, out_illegal=0, all buffer-valid flags 0, in_ready=1 in the cycle after reset.
- Reset asserted mid-stream discards every buffered entry. Inputs presented during reset are not accepted.

## Timing
- Latency: one cycle from accept to out_valid, when the output register is empty or drains in the same cycle.
- Throughput: one entry per cycle while out_ready is held high.
- Simultaneous accept and emit on a full output register: the new entry replaces the emitted one with no bubble.
- out_* are driven from registers only. There is no combinational path from in_instr to out_imm.

## Configuration
- IMM_EXTEND_PIPE_SKID_EN defined:
  - A second skid register is present.
  - in_ready = !skid_valid, driven directly from a register with no combinational dependence on out_ready.
  - When out_ready falls, one extra entry is absorbed into the skid register. That entry moves to the output register on the next emit.
- IMM_EXTEND_PIPE_SKID_EN undefined:
  - Only a single output register is present.
  - in_ready = !out_valid || out_ready, which is a combinational path from out_ready.

## Structure
- Shared package imm_pkg holds:
  - imm_src_e enum: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z.
  - IMM_SRC_W = 3.
  - Format encodings, shared with the control decoder.
- Sub-module imm_extend_decode: purely combinational format decode (instr, imm_src → XLEN imm and illegal flag), parametrised by XLEN. The top level contains only the handshake and buffer registers.

## Test plan
- I-type, XLEN=32: in_instr=0xFFF00093, src=000, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- B-type: in_instr=0xFE000EE3, src=010 → out_imm=0xFFFFFFFC.
- U-type, XLEN=64: in_instr=0x800000B7, src=011 → out_imm=0xFFFFFFFF80000000.
- Z and illegal formats: in_instr with [19:15]=11111, src=101 → out_imm=0x1F. Same instr with src=110 → out_imm=0, out_illegal=1.
- Backpressure: stream 4 instructions with out_ready=0 for 3 cycles.
  - With SKID_EN: 2 accepted, then in_ready=0.
  - Without SKID_EN: 1 accepted, then in_ready=0.
  - On release: all 4 emerge in order, values unchanged.
- Reset mid-stream: assert reset with both registers full → next cycle out_valid=0, out_imm=0, in_ready=1, and no stale entry emerges afterwards.
